// File: rtl/pingpong_ram_ctrl.sv
// ---------------------------------------------------------------------------
// pingpong_ram_ctrl
//
// Runs one true-dual-port RAM as a two-bank ping-pong buffer. Port A (write
// only) fills bank wr_bank while port B drains bank rd_bank, which the write
// side has already marked full. The bank is selected by the RAM address MSB.
// Ownership of each bank is handed over through bank_full: the write side
// sets the flag and the read side clears it.
//
// Optional build macro:
//   PINGPONG_OVERFLOW_DROP_EN - s_tready is tied high. A sample that arrives
//   while the current write bank is still full is dropped and counted in
//   overflow_cnt, which saturates at 16'hFFFF. When the macro is not defined,
//   the input stream is back-pressured and overflow_cnt is tied to 0.
//
// Ports:
//   clk, rst_n             single clock, asynchronous active-low reset
//   s_tdata/s_tvalid/      input sample stream
//   s_tready
//   m_tdata/m_tvalid/      output sample stream; m_tlast marks the last word
//   m_tready/m_tlast       of a bank
//   ram_wea/addra/dina     RAM port A (write)
//   ram_enb/addrb/doutb    RAM port B (read); doutb is valid 1 cycle after enb
//   bank_full              per-bank full flags (bit0 = bank 0)
//   overflow_cnt           number of dropped samples (drop build only)
// ---------------------------------------------------------------------------
module pingpong_ram_ctrl #(
    parameter int DATA_W = 14,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] s_tdata,
    input  logic              s_tvalid,
    output logic              s_tready,
    output logic [DATA_W-1:0] m_tdata,
    output logic              m_tvalid,
    input  logic              m_tready,
    output logic              m_tlast,
    output logic              ram_wea,
    output logic [ADDR_W:0]   ram_addra,
    output logic [DATA_W-1:0] ram_dina,
    output logic              ram_enb,
    output logic [ADDR_W:0]   ram_addrb,
    input  logic [DATA_W-1:0] ram_doutb,
    output logic [1:0]        bank_full,
    output logic [15:0]       overflow_cnt
);

    localparam logic [ADDR_W-1:0] CNT_MAX = '1;

    typedef enum logic {
        R_IDLE,
        R_DRAIN
    } rd_state_t;

    rd_state_t         rd_state;
    rd_state_t         rd_state_next;

    logic              wr_bank;
    logic [ADDR_W-1:0] wr_cnt;
    logic              rd_bank;
    logic [ADDR_W-1:0] rd_cnt;

    logic              wr_full;
    logic              accept;
    logic              wr_last;
    logic              rd_issue;
    logic              rd_last;
    logic [1:0]        bank_set;
    logic [1:0]        bank_clr;

    logic              inflight;
    logic              inflight_last;

    logic [DATA_W-1:0] fifo_data [2];
    logic              fifo_last [2];
    logic              fifo_wr_ptr;
    logic              fifo_rd_ptr;
    logic [1:0]        fifo_count;
    logic              fifo_pop;
    logic [2:0]        fifo_occ_next;
    logic              fifo_room;

    assign wr_full = bank_full[wr_bank];

`ifdef PINGPONG_OVERFLOW_DROP_EN
    logic drop;

    assign s_tready = 1'b1;
    assign accept   = s_tvalid & ~wr_full;
    assign drop     = s_tvalid & wr_full;

    // Dropped samples are counted until the counter saturates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_cnt <= '0;
        end else if (drop && (overflow_cnt != 16'hFFFF)) begin
            overflow_cnt <= overflow_cnt + 16'd1;
        end
    end
`else
    assign s_tready     = ~wr_full;
    assign accept       = s_tvalid & s_tready;
    assign overflow_cnt = '0;
`endif

    assign wr_last = accept && (wr_cnt == CNT_MAX);

    // Port A is registered, so an accepted sample is written one cycle
    // later. The bank is handed to the read side on the edge that accepts
    // its last word; the RAM write of that word lands before the read FSM
    // can leave R_IDLE, so the first read never overtakes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_wea   <= 1'b0;
            ram_addra <= '0;
            ram_dina  <= '0;
            wr_cnt    <= '0;
            wr_bank   <= 1'b0;
        end else begin
            ram_wea <= accept;
            if (accept) begin
                ram_addra <= {wr_bank, wr_cnt};
                ram_dina  <= s_tdata;
                wr_cnt    <= wr_cnt + 1'b1;
                if (wr_cnt == CNT_MAX) begin
                    wr_bank <= ~wr_bank;
                end
            end
        end
    end

    // Set and clear always target different banks, so both can be applied
    // on the same edge without priority concerns.
    always_comb begin
        bank_set = '0;
        bank_clr = '0;
        if (wr_last) begin
            bank_set[wr_bank] = 1'b1;
        end
        if (rd_last) begin
            bank_clr[rd_bank] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_full <= '0;
        end else begin
            bank_full <= (bank_full | bank_set) & ~bank_clr;
        end
    end

    // Output skid FIFO occupancy as it will be after this cycle's pop and
    // after any read already in flight has landed. Counting the pop lets the
    // drain run at one word per cycle while m_tready stays high.
    assign fifo_pop      = m_tvalid & m_tready;
    assign fifo_occ_next = {1'b0, fifo_count} - {2'b00, fifo_pop} + {2'b00, inflight};
    assign fifo_room     = (fifo_occ_next < 3'd2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_state <= R_IDLE;
        end else begin
            rd_state <= rd_state_next;
        end
    end

    // Read FSM: wait in R_IDLE for the current read bank to fill, then issue
    // one read per cycle whenever the skid FIFO can absorb the result.
    always_comb begin
        rd_state_next = rd_state;
        rd_issue      = 1'b0;
        case (rd_state)
            R_IDLE: begin
                if (bank_full[rd_bank]) begin
                    rd_state_next = R_DRAIN;
                end
            end
            R_DRAIN: begin
                if (fifo_room) begin
                    rd_issue = 1'b1;
                    if (rd_cnt == CNT_MAX) begin
                        rd_state_next = R_IDLE;
                    end
                end
            end
            default: rd_state_next = R_IDLE;
        endcase
    end

    assign rd_last   = rd_issue && (rd_cnt == CNT_MAX);
    assign ram_enb   = rd_issue;
    assign ram_addrb = {rd_bank, rd_cnt};

    // Issuing the last address releases the bank to the write side. The
    // write port can only reuse it from the next cycle on, after the RAM has
    // already sampled that read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_cnt        <= '0;
            rd_bank       <= 1'b0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
        end else begin
            inflight      <= rd_issue;
            inflight_last <= rd_last;
            if (rd_state == R_IDLE && bank_full[rd_bank]) begin
                rd_cnt <= '0;
            end else if (rd_issue) begin
                rd_cnt <= rd_cnt + 1'b1;
            end
            if (rd_last) begin
                rd_bank <= ~rd_bank;
            end
        end
    end

    // Two-entry skid FIFO. Read data is captured the cycle after issue. The
    // head entry is not touched while it is waiting for m_tready, so
    // m_tdata/m_tlast stay stable during a stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                fifo_data[i] <= '0;
                fifo_last[i] <= 1'b0;
            end
            fifo_wr_ptr <= 1'b0;
            fifo_rd_ptr <= 1'b0;
            fifo_count  <= '0;
        end else begin
            if (inflight) begin
                fifo_data[fifo_wr_ptr] <= ram_doutb;
                fifo_last[fifo_wr_ptr] <= inflight_last;
                fifo_wr_ptr            <= ~fifo_wr_ptr;
            end
            if (fifo_pop) begin
                fifo_rd_ptr <= ~fifo_rd_ptr;
            end
            fifo_count <= fifo_count + {1'b0, inflight} - {1'b0, fifo_pop};
        end
    end

    assign m_tvalid = (fifo_count != 2'd0);
    assign m_tdata  = fifo_data[fifo_rd_ptr];
    assign m_tlast  = fifo_last[fifo_rd_ptr];

endmodule

// File: tb/tb_pingpong_ram_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pingpong_ram_ctrl
//
// Directed testbench for pingpong_ram_ctrl with a behavioural dual-port RAM.
// Every accepted input sample is queued with its expected tlast flag, and
// each output pop is compared against the head of that queue. RAM port
// addresses are checked against running write/read indices. The
// drop-on-overflow scenario is built only when PINGPONG_OVERFLOW_DROP_EN is
// defined.
// ---------------------------------------------------------------------------
module tb_pingpong_ram_ctrl;

    localparam int DATA_W = 14;
    localparam int ADDR_W = 10;

    typedef struct packed {
        logic              last;
        logic [DATA_W-1:0] data;
    } exp_t;

    logic              clk;
    logic              rst_n;
    logic [DATA_W-1:0] s_tdata;
    logic              s_tvalid;
    logic              s_tready;
    logic [DATA_W-1:0] m_tdata;
    logic              m_tvalid;
    logic              m_tready;
    logic              m_tlast;
    logic              ram_wea;
    logic [ADDR_W:0]   ram_addra;
    logic [DATA_W-1:0] ram_dina;
    logic              ram_enb;
    logic [ADDR_W:0]   ram_addrb;
    logic [DATA_W-1:0] ram_doutb;
    logic [1:0]        bank_full;
    logic [15:0]       overflow_cnt;

    logic [DATA_W-1:0] ram_mem [2**(ADDR_W+1)];

    exp_t              exp_q [$];
    int                vectors      = 0;
    int                miscompares  = 0;
    int                push_count   = 0;
    int                push_limit   = 32'h7FFF_FFFF;
    int                write_idx    = 0;
    int                read_idx     = 0;
    int                last_seen    = 0;
    bit                random_ready = 1'b0;
    logic              stall_prev   = 1'b0;
    logic [DATA_W-1:0] held_data    = '0;
    logic              held_last    = 1'b0;

    pingpong_ram_ctrl #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .s_tdata     (s_tdata),
        .s_tvalid    (s_tvalid),
        .s_tready    (s_tready),
        .m_tdata     (m_tdata),
        .m_tvalid    (m_tvalid),
        .m_tready    (m_tready),
        .m_tlast     (m_tlast),
        .ram_wea     (ram_wea),
        .ram_addra   (ram_addra),
        .ram_dina    (ram_dina),
        .ram_enb     (ram_enb),
        .ram_addrb   (ram_addrb),
        .ram_doutb   (ram_doutb),
        .bank_full   (bank_full),
        .overflow_cnt(overflow_cnt)
    );

    // 100 MHz clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural true-dual-port RAM with a one-cycle registered read.
    always @(posedge clk) begin
        if (ram_wea) begin
            ram_mem[ram_addra] <= ram_dina;
        end
        if (ram_enb) begin
            ram_doutb <= ram_mem[ram_addrb];
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Monitor on the falling edge: records accepted samples, checks RAM
    // addressing order, output data/tlast order and stall stability.
    always @(negedge clk) begin
        if (rst_n) begin
            if (s_tvalid && s_tready && (push_count < push_limit)) begin
                exp_q.push_back({((push_count % 1024) == 1023), s_tdata});
                push_count++;
            end
            if (ram_wea) begin
                checkOutput("ram_addra", 32'(ram_addra), write_idx % 2048);
                write_idx++;
            end
            if (ram_enb) begin
                checkOutput("ram_addrb", 32'(ram_addrb), read_idx % 2048);
                read_idx++;
            end
            if (stall_prev) begin
                checkOutput("hold_valid", 32'(m_tvalid), 1);
                checkOutput("hold_data", 32'(m_tdata), 32'(held_data));
                checkOutput("hold_last", 32'(m_tlast), 32'(held_last));
            end
            if (m_tvalid && m_tready) begin
                if (exp_q.size() == 0) begin
                    checkOutput("spurious_out", 32'(m_tdata), 32'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    checkOutput("m_tdata", 32'(m_tdata), 32'(e.data));
                    checkOutput("m_tlast", 32'(m_tlast), 32'(e.last));
                end
                if (m_tlast) begin
                    last_seen++;
                end
            end
            stall_prev = m_tvalid && !m_tready;
            held_data  = m_tdata;
            held_last  = m_tlast;
        end else begin
            stall_prev = 1'b0;
        end
    end

    // Asserts reset, checks that every output is zero, clears the bench
    // model and releases reset. Called 1 time unit after a rising edge.
    task automatic resetDut();
        rst_n    = 1'b0;
        s_tvalid = 1'b0;
        s_tdata  = '0;
        #1;
        checkOutput("rst_m_tvalid", 32'(m_tvalid), 0);
        checkOutput("rst_m_tdata", 32'(m_tdata), 0);
        checkOutput("rst_m_tlast", 32'(m_tlast), 0);
        checkOutput("rst_ram_wea", 32'(ram_wea), 0);
        checkOutput("rst_ram_addra", 32'(ram_addra), 0);
        checkOutput("rst_ram_dina", 32'(ram_dina), 0);
        checkOutput("rst_ram_enb", 32'(ram_enb), 0);
        checkOutput("rst_ram_addrb", 32'(ram_addrb), 0);
        checkOutput("rst_bank_full", 32'(bank_full), 0);
        checkOutput("rst_overflow", 32'(overflow_cnt), 0);
        exp_q.delete();
        push_count = 0;
        write_idx  = 0;
        read_idx   = 0;
        last_seen  = 0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Streams count consecutive values starting at start_val, advancing only
    // on cycles where the sample was accepted. Returns 1 time unit after the
    // edge that accepted the last sample.
    task automatic applyStimulus(input int start_val, input int count, input int max_cycles);
        int   sent = 0;
        int   cyc  = 0;
        logic took;
        while (sent < count && cyc < max_cycles) begin
            s_tvalid = 1'b1;
            s_tdata  = DATA_W'(start_val + sent);
            if (random_ready) begin
                m_tready = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            took = s_tready;
            @(posedge clk);
            #1;
            cyc++;
            if (took) begin
                sent++;
            end
        end
        s_tvalid = 1'b0;
        checkOutput("stream_sent", sent, count);
    endtask

    // Runs until the expected queue has shrunk to remaining entries.
    task automatic waitDrain(input int remaining, input int max_cycles);
        int cyc = 0;
        while (exp_q.size() > remaining && cyc < max_cycles) begin
            if (random_ready) begin
                m_tready = 1'($urandom_range(0, 1));
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        checkOutput("drain_left", exp_q.size(), remaining);
    endtask

    initial begin
        rst_n    = 1'b1;
        s_tvalid = 1'b0;
        s_tdata  = '0;
        m_tready = 1'b0;
        @(posedge clk);
        #1;

        // Single bank: 0..1023 with the sink always ready.
        $display("[TB] single bank stream");
        resetDut();
        m_tready = 1'b1;
        applyStimulus(0, 1024, 1200);
        checkOutput("bf_after_1024", 32'(bank_full), 32'h1);
        waitDrain(0, 2000);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("bf_drained", 32'(bank_full), 0);
        checkOutput("m_tvalid_idle", 32'(m_tvalid), 0);
        checkOutput("tlast_count_1", last_seen, 1);

        // Three banks back to back: bank order 0,1,0 on both ports.
        $display("[TB] three bank stream");
        resetDut();
        m_tready = 1'b1;
        applyStimulus(0, 3072, 3500);
        waitDrain(0, 3000);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("writes_3072", write_idx, 3072);
        checkOutput("reads_3072", read_idx, 3072);
        checkOutput("tlast_count_3", last_seen, 3);
        checkOutput("bf_drained_3", 32'(bank_full), 0);

`ifndef PINGPONG_OVERFLOW_DROP_EN
        // Backpressure: both banks fill, input stalls, then release.
        $display("[TB] backpressure");
        begin
            bit found = 1'b0;
            resetDut();
            m_tready = 1'b0;
            applyStimulus(0, 2048, 2300);
            checkOutput("bf_both_full", 32'(bank_full), 32'h3);
            checkOutput("s_tready_full", 32'(s_tready), 0);
            s_tvalid = 1'b1;
            s_tdata  = DATA_W'(2048);
            repeat (10) begin
                @(negedge clk);
                checkOutput("s_tready_stall", 32'(s_tready), 0);
            end
            @(posedge clk);
            #1;
            s_tvalid = 1'b0;
            m_tready = 1'b1;
            for (int cyc = 0; cyc < 3000 && !found; cyc++) begin
                @(negedge clk);
                if (ram_enb && ram_addrb == 11'd1023) begin
                    found = 1'b1;
                    checkOutput("s_tready_last_rd", 32'(s_tready), 0);
                end
            end
            checkOutput("bank0_last_read", 32'(found), 1);
            @(posedge clk);
            #1;
            checkOutput("s_tready_release", 32'(s_tready), 1);
            applyStimulus(2048, 52, 300);
            waitDrain(52, 3000);
            repeat (3) @(posedge clk);
            #1;
            checkOutput("bf_bp_end", 32'(bank_full), 0);
            checkOutput("overflow_zero", 32'(overflow_cnt), 0);
        end
`endif

        // Random sink readiness.
        $display("[TB] random m_tready");
        resetDut();
        random_ready = 1'b1;
        applyStimulus(100, 2048, 8000);
        waitDrain(0, 8000);
        random_ready = 1'b0;
        m_tready     = 1'b1;
        checkOutput("tlast_count_rand", last_seen, 2);

        // Reset in the middle of filling bank 0, then fresh data.
        $display("[TB] mid-operation reset");
        resetDut();
        m_tready = 1'b1;
        applyStimulus(7, 500, 600);
        resetDut();
        m_tready = 1'b1;
        applyStimulus(5000, 1024, 1200);
        waitDrain(0, 2000);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("m_tvalid_after_rst", 32'(m_tvalid), 0);
        checkOutput("tlast_count_rst", last_seen, 1);

`ifdef PINGPONG_OVERFLOW_DROP_EN
        // Drop mode: 2048 samples fit, the remaining 100 are dropped.
        $display("[TB] overflow drop");
        resetDut();
        push_limit = 2048;
        m_tready   = 1'b0;
        applyStimulus(0, 2148, 2300);
        checkOutput("overflow_cnt", 32'(overflow_cnt), 100);
        checkOutput("writes_drop", write_idx, 2048);
        m_tready = 1'b1;
        waitDrain(0, 3000);
        push_limit = 32'h7FFF_FFFF;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
